// File: rtl/rom_sequencer.sv
// Pose-ROM playback sequencer: walks the pose table, latches the servo positions
// and holds each pose for tiempo time units before fetching the next entry.
module rom_sequencer #(
    parameter int unsigned TICK_CYCLES = 1_000_000,
    parameter logic [7:0]  START_ADDR  = 8'h00,
    parameter logic [7:0]  END_ADDR    = 8'h0B
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    input  logic        stop,
    input  logic        loop_en,
    input  logic [31:0] DATOS,
    output logic [7:0]  address,
    output logic [7:0]  servo1,
    output logic [7:0]  servo2,
    output logic [7:0]  servo3,
    output logic        pos_valid,
    output logic        busy,
    output logic        done
);

    localparam int unsigned TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_LATCH,
        S_HOLD
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    addr_q,  addr_d;
    logic [7:0]    s1_q,    s1_d;
    logic [7:0]    s2_q,    s2_d;
    logic [7:0]    s3_q,    s3_d;
    logic          pv_q,    pv_d;
    logic          busy_q,  busy_d;
    logic          done_q,  done_d;
    logic [TW-1:0] tick_q,  tick_d;
    logic [7:0]    unit_q,  unit_d;

    logic [7:0] tiempo;
    assign tiempo = DATOS[7:0];

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        s3_d    = s3_q;
        pv_d    = pv_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        tick_d  = tick_q;
        unit_d  = unit_q;

        if (stop) begin
            // Abort leaves address, servos and pos_valid untouched.
            state_d = S_IDLE;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_READ;
                        addr_d  = START_ADDR;
                        busy_d  = 1'b1;
                    end
                end
                S_READ: begin
                    state_d = S_LATCH;
                end
                S_LATCH: begin
                    if (tiempo == 8'd0) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_HOLD;
                        s1_d    = DATOS[31:24];
                        s2_d    = DATOS[23:16];
                        s3_d    = DATOS[15:8];
                        pv_d    = 1'b1;
                        unit_d  = tiempo;
                        tick_d  = '0;
                    end
                end
                S_HOLD: begin
                    if (tick_q == TICK_LAST) begin
                        tick_d = '0;
                        unit_d = unit_q - 8'd1;
                        // Last unit expired: move on, wrap around, or finish.
                        if (unit_q == 8'd1) begin
                            if (addr_q != END_ADDR) begin
                                addr_d  = addr_q + 8'd1;
                                state_d = S_READ;
                            end else if (loop_en) begin
                                addr_d  = START_ADDR;
                                state_d = S_READ;
                            end else begin
                                state_d = S_IDLE;
                                busy_d  = 1'b0;
                                done_d  = 1'b1;
                            end
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            addr_q  <= START_ADDR;
            s1_q    <= '0;
            s2_q    <= '0;
            s3_q    <= '0;
            pv_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            tick_q  <= '0;
            unit_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            s3_q    <= s3_d;
            pv_q    <= pv_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            tick_q  <= tick_d;
            unit_q  <= unit_d;
        end
    end

    assign address   = addr_q;
    assign servo1    = s1_q;
    assign servo2    = s2_q;
    assign servo3    = s3_q;
    assign pos_valid = pv_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
